// File: rtl/mskaes_mc_colseq_pkg.sv
// Shared constants, FSM encoding and bus-offset helpers for the column-serial
// masked MixColumns sequencer.
package mskaes_mc_colseq_pkg;

    localparam int STATE_BYTES = 16;
    localparam int COLS        = 4;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Offset of byte n on a d-share bus.
    function automatic int byte_off(input int d, input int n);
        return BYTE_W * d * n;
    endfunction

    // Offset of column c on a d-share bus.
    function automatic int col_off(input int d, input int c);
        return (STATE_BYTES / COLS) * BYTE_W * d * c;
    endfunction

    // Position of bit k of share s inside one byte slot.
    function automatic int bit_idx(input int d, input int k, input int s);
        return k * d + s;
    endfunction

    // GF(2^8) multiply-by-two with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mskaes_mc_colseq_col_select.sv
// Share-wise column mux, masked MixColumns datapath with bypass, and the
// column write-enable decode for the result register.
module mskaes_mc_colseq_col_select
    import mskaes_mc_colseq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [STATE_BYTES*BYTE_W*d-1:0] state,
    input  logic [1:0]                      col,
    input  logic                            bypass,
    input  logic                            en,
    output logic [4*BYTE_W*d-1:0]           col_out,
    output logic [COLS-1:0]                 wr_en
);

    localparam int COL_W = 4 * BYTE_W * d;

    logic [COL_W-1:0]                 col_in;
    logic [COL_W-1:0]                 mc_out;
    logic [d-1:0][3:0][BYTE_W-1:0]    a;
    logic [d-1:0][3:0][BYTE_W-1:0]    b;

    // Column mux: selection depends only on the public column index.
    always_comb begin
        col_in = '0;
        case (col)
            2'd0:    col_in = state[col_off(d, 0) +: COL_W];
            2'd1:    col_in = state[col_off(d, 1) +: COL_W];
            2'd2:    col_in = state[col_off(d, 2) +: COL_W];
            default: col_in = state[col_off(d, 3) +: COL_W];
        endcase
    end

    // Unpack the interleaved bus into per-share bytes and back again.
    for (genvar s = 0; s < d; s++) begin : g_share
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar k = 0; k < BYTE_W; k++) begin : g_bit
                assign a[s][r][k] = col_in[byte_off(d, r) + bit_idx(d, k, s)];
                assign mc_out[byte_off(d, r) + bit_idx(d, k, s)] = b[s][r][k];
            end
        end

        // MixColumns is linear, so each share is transformed independently.
        always_comb begin
            b[s][0] = xtime(a[s][0]) ^ xtime(a[s][1]) ^ a[s][1] ^ a[s][2] ^ a[s][3];
            b[s][1] = a[s][0] ^ xtime(a[s][1]) ^ xtime(a[s][2]) ^ a[s][2] ^ a[s][3];
            b[s][2] = a[s][0] ^ a[s][1] ^ xtime(a[s][2]) ^ xtime(a[s][3]) ^ a[s][3];
            b[s][3] = xtime(a[s][0]) ^ a[s][0] ^ a[s][1] ^ a[s][2] ^ xtime(a[s][3]);
        end
    end

    // Bypass passes the selected column through untouched (final round).
    always_comb begin
        col_out = bypass ? col_in : mc_out;
        wr_en   = en ? (4'b0001 << col) : 4'b0000;
    end

endmodule

// File: rtl/mskaes_mc_colseq.sv
// Column-serial sequencer: accepts a d-share AES state, runs its four columns
// through one shared masked MixColumns unit, and returns the registered result.
//
// state | meaning
// IDLE  | waiting for an input state, in_ready high
// RUN   | processing column col, one column per cycle
// DONE  | result presented, waiting for out_ready
module mskaes_mc_colseq
    import mskaes_mc_colseq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_bypass,
    input  logic [STATE_BYTES*BYTE_W*d-1:0] in_state,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [STATE_BYTES*BYTE_W*d-1:0] out_state,
    output logic                            busy
);

    localparam int STATE_W = STATE_BYTES * BYTE_W * d;
    localparam int COL_W   = 4 * BYTE_W * d;

    fsm_t               fsm_q, fsm_d;
    logic [1:0]         col_q;
    logic               bypass_q;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] result_q;
    logic               load;
    logic               run;
    logic [COL_W-1:0]   col_out;
    logic [COLS-1:0]    wr_en;

    mskaes_mc_colseq_col_select #(.d(d)) u_col_select (
        .state   (state_q),
        .col     (col_q),
        .bypass  (bypass_q),
        .en      (run),
        .col_out (col_out),
        .wr_en   (wr_en)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= ST_IDLE;
        else        fsm_q <= fsm_d;
    end

    // Next-state and handshake decode; DONE allows a back-to-back accept.
    always_comb begin
        fsm_d    = fsm_q;
        load     = 1'b0;
        run      = 1'b0;
        in_ready = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load  = 1'b1;
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
                if (col_q == 2'd3) fsm_d = ST_DONE;
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load  = 1'b1;
                        fsm_d = ST_RUN;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Input capture and column counter; col wraps to 0 after column 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '0;
            bypass_q <= 1'b0;
            col_q    <= 2'd0;
        end else if (load) begin
            state_q  <= in_state;
            bypass_q <= in_bypass;
            col_q    <= 2'd0;
        end else if (run) begin
            col_q    <= col_q + 2'd1;
        end
    end

    // Result register, written one column per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_en[c]) result_q[col_off(d, c) +: COL_W] <= col_out;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = (fsm_q == ST_DONE);
        busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
        out_state = result_q;
    end

endmodule

// File: tb/tb_mskaes_mc_colseq.sv
// Randomized self-checking bench for mskaes_mc_colseq against a share-wise
// MixColumns reference built from GF(2^8) arithmetic.
module tb_mskaes_mc_colseq;

    localparam int D = 2;
    localparam int W = 128 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_bypass = 1'b0;
    logic [W-1:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_state;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    mskaes_mc_colseq #(.d(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bypass (in_bypass),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [W-1:0] bus, input int s, input int n);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = bus[8*D*n + k*D + s];
        return r;
    endfunction

    function automatic logic [W-1:0] set_byte(input logic [W-1:0] bus, input int s, input int n,
                                              input logic [7:0] v);
        logic [W-1:0] r;
        r = bus;
        for (int k = 0; k < 8; k++) r[8*D*n + k*D + s] = v[k];
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, a, b;
        logic       hi;
        p = 0; a = x; b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    // Reference: every share goes through MixColumns on its own (circulant 2,3,1,1).
    function automatic logic [W-1:0] model(input logic [W-1:0] bus, input logic byp);
        logic [W-1:0] r;
        logic [7:0]   a [4];
        logic [7:0]   v;
        r = '0;
        for (int s = 0; s < D; s++)
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = get_byte(bus, s, 4*c + j);
                for (int i = 0; i < 4; i++) begin
                    v = gf_mul(8'h02, a[i]) ^ gf_mul(8'h03, a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
                    r = set_byte(r, s, 4*c + i, byp ? a[i] : v);
                end
            end
        return r;
    endfunction

    // Unmasked column c as {row0,row1,row2,row3}.
    function automatic logic [31:0] recomb(input logic [W-1:0] bus, input int c);
        logic [31:0] r;
        logic [7:0]  v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = '0;
            for (int s = 0; s < D; s++) v ^= get_byte(bus, s, 4*c + i);
            r[31-8*i -: 8] = v;
        end
        return r;
    endfunction

    // Two-share encoding: share1 = mask, share0 = plain ^ mask; byte n at plain[8n+7:8n].
    function automatic logic [W-1:0] mask_state(input logic [127:0] plain, input logic [127:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r = set_byte(r, 1, n, m[8*n +: 8]);
            r = set_byte(r, 0, n, plain[8*n +: 8] ^ m[8*n +: 8]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bus();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] st, input logic byp);
        @(negedge clk);
        chk("in_ready_before_send", W'(in_ready), W'(1));
        in_state  = st;
        in_bypass = byp;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", W'(busy), W'(1));
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 20);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic [W-1:0] st, input logic byp);
        int cyc;
        send(st, byp);
        wait_out(cyc);
        chk({tag, "_latency"}, W'(cyc), W'(4));
        chk(tag, out_state, model(st, byp));
        take();
    endtask

    initial begin
        logic [127:0] plain;
        logic [W-1:0] st, st2, snap, exp1;
        int           cyc;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_out_state", out_state, '0);
        chk("reset_busy", W'(busy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", W'(in_ready), W'(1));

        // Known column with fixed mask 0x5A.
        plain = '0;
        plain[31:0]   = {8'h45, 8'h53, 8'h13, 8'hdb};
        plain[63:32]  = {4{8'h01}};
        plain[95:64]  = {4{8'hc6}};
        plain[127:96] = {4{8'h01}};
        st = mask_state(plain, {16{8'h5a}});
        send(st, 1'b0);
        wait_out(cyc);
        chk("basic_latency", W'(cyc), W'(4));
        chk("basic_col0", W'(recomb(out_state, 0)), W'(32'h8e4da1bc));
        chk("basic_col1", W'(recomb(out_state, 1)), W'(32'h01010101));
        chk("basic_col2", W'(recomb(out_state, 2)), W'(32'hc6c6c6c6));
        chk("basic_col3", W'(recomb(out_state, 3)), W'(32'h01010101));
        chk("basic_shares", out_state, model(st, 1'b0));
        take();
        chk("idle_after_take", W'(busy), W'(0));

        // Second known column, random mask.
        plain = {$urandom, $urandom, $urandom, $urandom};
        plain[31:0] = {8'h5c, 8'h22, 8'h0a, 8'hf2};
        st = mask_state(plain, {$urandom, $urandom, $urandom, $urandom});
        send(st, 1'b0);
        wait_out(cyc);
        chk("vec2_latency", W'(cyc), W'(4));
        chk("vec2_col0", W'(recomb(out_state, 0)), W'(32'h9fdc589d));
        chk("vec2_shares", out_state, model(st, 1'b0));
        take();

        // Bypass.
        st = rand_bus();
        send(st, 1'b1);
        wait_out(cyc);
        chk("bypass_latency", W'(cyc), W'(4));
        chk("bypass_data", out_state, st);
        take();

        // Random transactions.
        for (int i = 0; i < 8; i++) do_txn("random", rand_bus(), 1'($urandom_range(0, 1)));

        // Backpressure then back-to-back accept.
        st  = rand_bus();
        st2 = rand_bus();
        send(st, 1'b0);
        wait_out(cyc);
        chk("bp_latency", W'(cyc), W'(4));
        snap = out_state;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_stable", out_state, snap);
            chk("bp_in_ready", W'(in_ready), W'(0));
        end
        chk("bp_result", snap, model(st, 1'b0));
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = st2;
        in_bypass = 1'b0;
        #1;
        chk("b2b_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_busy", W'(busy), W'(1));
        chk("b2b_out_valid_drop", W'(out_valid), W'(0));
        wait_out(cyc);
        chk("b2b_latency", W'(cyc), W'(4));
        chk("b2b_result", out_state, model(st2, 1'b0));
        take();

        // Reset in the middle of RUN (col = 2).
        send(rand_bus(), 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_out_state", out_state, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        do_txn("after_reset", rand_bus(), 1'b0);

        // in_valid pulsed during RUN must be ignored.
        st   = rand_bus();
        exp1 = model(st, 1'b0);
        send(st, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_state = rand_bus();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        wait_out(cyc);
        chk("proto_latency", W'(cyc), W'(2));
        chk("proto_result", out_state, exp1);
        take();
        chk("proto_idle", W'(busy), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
